// File: rtl/decode_stage_if.sv
// -----------------------------------------------------------------------------
// decode_stage_if
//   Bundles the fetch-side and execute-side handshake buses of decode_stage.
//
//   Fetch side (into the stage):
//     in_valid / in_ready   valid/ready handshake for one instruction
//     in_instr              raw 32-bit instruction word
//     in_pc                 PC of in_instr (XLEN wide)
//   Execute side (out of the stage):
//     out_valid / out_ready valid/ready handshake for one decoded bundle
//     out_pc ... out_illegal decoded fields
//
//   Modports:
//     master  the environment around the stage (fetch driver + execute sink)
//     slave   the decode stage itself
// -----------------------------------------------------------------------------
interface decode_stage_if #(
    parameter int unsigned XLEN = 32
) ();

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [5:0]      out_fmt;
    logic [6:0]      out_opcode;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic            out_rd_we;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_fmt, out_opcode, out_funct3, out_funct7,
               out_rd, out_rs1, out_rs2, out_rd_we, out_imm, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_fmt, out_opcode, out_funct3, out_funct7,
               out_rd, out_rs1, out_rs2, out_rd_we, out_imm, out_illegal
    );

endinterface

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   RV32I/RV64I instruction decode stage. Accepts an instruction + PC over a
//   valid/ready handshake, classifies its format (R/I/S/B/U/J), extracts the
//   register and function fields, builds the sign-extended immediate and flags
//   unsupported encodings. The decoded bundle is registered; with SKID_EN=1 a
//   one-entry skid buffer lets in_ready come straight from a flop.
//
//   Parameters:
//     XLEN     width of pc and imm (32 or 64)
//     SKID_EN  1: skid buffer present, in_ready registered
//              0: output register only, in_ready = out_ready | !out_valid
//
//   Ports:
//     clk      clock, rising edge
//     rst_n    asynchronous active-low reset
//     flush    drop everything held or arriving this cycle (branch redirect)
//     bus      decode_stage_if.slave: fetch-side in_* and execute-side out_*
//
//   out_fmt is one-hot {J,U,B,S,I,R}. Illegal encodings carry every field as
//   zero (pc still passes through) and out_illegal=1; they flow like any other.
// -----------------------------------------------------------------------------
module decode_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SKID_EN = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    decode_stage_if.slave bus
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpOpImm  = 7'b0010011;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    // One-hot format codes, bit order {J,U,B,S,I,R}
    localparam logic [5:0] FmtR = 6'b000001;
    localparam logic [5:0] FmtI = 6'b000010;
    localparam logic [5:0] FmtS = 6'b000100;
    localparam logic [5:0] FmtB = 6'b001000;
    localparam logic [5:0] FmtU = 6'b010000;
    localparam logic [5:0] FmtJ = 6'b100000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [5:0]      fmt;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            rd_we;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } bundle_t;

    typedef enum logic [1:0] {
        StEmpty,  // output register empty
        StOne,    // output register full, skid empty
        StFull    // output register and skid both full
    } state_e;

    // Every immediate is first formed as a 32-bit value whose bit 31 is the
    // sign, then widened; this keeps RV64 correct without per-format widths.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    function automatic bundle_t decode(input logic [31:0] instr, input logic [XLEN-1:0] pc);
        bundle_t     b;
        logic [31:0] imm32;
        b     = '0;
        imm32 = '0;
        b.pc  = pc;
        // Opcodes all end in 2'b11, so instr[1:0]!=2'b11 falls into default.
        case (instr[6:0])
            OpOp: begin
                b.fmt    = FmtR;
                b.funct3 = instr[14:12];
                b.funct7 = instr[31:25];
                b.rd     = instr[11:7];
                b.rs1    = instr[19:15];
                b.rs2    = instr[24:20];
                b.rd_we  = 1'b1;
            end
            OpLoad, OpOpImm, OpJalr, OpSystem: begin
                b.fmt    = FmtI;
                b.funct3 = instr[14:12];
                b.rd     = instr[11:7];
                b.rs1    = instr[19:15];
                b.rd_we  = 1'b1;
                imm32    = {{20{instr[31]}}, instr[31:20]};
            end
            OpStore: begin
                b.fmt    = FmtS;
                b.funct3 = instr[14:12];
                b.rs1    = instr[19:15];
                b.rs2    = instr[24:20];
                imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OpBranch: begin
                b.fmt    = FmtB;
                b.funct3 = instr[14:12];
                b.rs1    = instr[19:15];
                b.rs2    = instr[24:20];
                imm32    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            end
            OpLui, OpAuipc: begin
                b.fmt   = FmtU;
                b.rd    = instr[11:7];
                b.rd_we = 1'b1;
                imm32   = {instr[31:12], 12'b0};
            end
            OpJal: begin
                b.fmt   = FmtJ;
                b.rd    = instr[11:7];
                b.rd_we = 1'b1;
                imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                           instr[30:21], 1'b0};
            end
            default: begin
                b.illegal = 1'b1;
            end
        endcase
        if (!b.illegal) begin
            b.opcode = instr[6:0];
        end
        b.imm = sext32(imm32);
        return b;
    endfunction

    state_e  state_q, state_d;
    bundle_t out_q, out_d;
    bundle_t skid_q, skid_d;
    bundle_t dec;

    logic in_ready;
    logic out_valid;
    logic in_fire;
    logic out_fire;
    logic load_out_in;
    logic load_out_skid;
    logic load_skid;

    assign dec      = decode(bus.in_instr, bus.in_pc);
    assign in_fire  = bus.in_valid & in_ready;
    assign out_fire = out_valid & bus.out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            // A coincident downstream handshake still completes; only the
            // stage contents are discarded.
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (in_fire && !out_fire && (SKID_EN != 0)) begin
                        state_d = StFull;
                    end else if (!in_fire && out_fire) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (out_fire) begin
                        state_d = StOne;
                    end
                end
                default: begin
                    state_d = StEmpty;
                end
            endcase
        end
    end

    // Output / control logic
    always_comb begin
        out_valid = (state_q != StEmpty);
        if (SKID_EN != 0) begin
            in_ready = (state_q != StFull);
        end else begin
            in_ready = bus.out_ready | (state_q == StEmpty);
        end
        load_out_in   = !flush && in_fire &&
                        ((state_q == StEmpty) || ((state_q == StOne) && out_fire));
        load_skid     = !flush && in_fire && (state_q == StOne) && !out_fire &&
                        (SKID_EN != 0);
        load_out_skid = !flush && (state_q == StFull) && out_fire;
    end

    // Data registers: the skid entry is always older than anything arriving,
    // so it refills the output register before new input is accepted.
    always_comb begin
        out_d  = out_q;
        skid_d = skid_q;
        if (load_out_in) begin
            out_d = dec;
        end else if (load_out_skid) begin
            out_d = skid_q;
        end
        if (load_skid) begin
            skid_d = dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            out_q  <= out_d;
            skid_q <= skid_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_pc      = out_q.pc;
    assign bus.out_fmt     = out_q.fmt;
    assign bus.out_opcode  = out_q.opcode;
    assign bus.out_funct3  = out_q.funct3;
    assign bus.out_funct7  = out_q.funct7;
    assign bus.out_rd      = out_q.rd;
    assign bus.out_rs1     = out_q.rs1;
    assign bus.out_rs2     = out_q.rs2;
    assign bus.out_rd_we   = out_q.rd_we;
    assign bus.out_imm     = out_q.imm;
    assign bus.out_illegal = out_q.illegal;

endmodule
